// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALUop values, R-type Funct codes,
// 4-bit ALU control codes and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] AluOpMem     = 2'b00;
    localparam logic [1:0] AluOpBranch  = 2'b01;
    localparam logic [1:0] AluOpRtype   = 2'b10;
    localparam logic [1:0] AluOpIllegal = 2'b11;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;
    localparam logic [5:0] FunctNor = 6'b100111;
    localparam logic [5:0] FunctMul = 6'b100001;
    localparam logic [5:0] FunctDiv = 6'b100011;

    typedef enum logic [3:0] {
        CtrlAnd  = 4'b0000,
        CtrlOr   = 4'b0001,
        CtrlAdd  = 4'b0010,
        CtrlMul  = 4'b0100,
        CtrlDiv  = 4'b0101,
        CtrlSub  = 4'b0110,
        CtrlSlt  = 4'b0111,
        CtrlNor  = 4'b1100,
        CtrlNone = 4'b1111  // undecoded request: completes with zero result
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the EX-stage issue logic and alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUop;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic             Zero;
    logic             div_zero;
    logic             illegal;

    modport master (
        output in_valid, ALUop, Funct, A, B,
        input  in_ready, out_valid, Result, Hi, Zero, div_zero, illegal
    );

    modport slave (
        input  in_valid, ALUop, Funct, A, B,
        output in_ready, out_valid, Result, Hi, Zero, div_zero, illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUop/Funct -> ALU control code decoder; holds no state.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctrl_e  ctrl,
    output logic       illegal
);

    // Map the request onto a control code, flagging anything not listed.
    always_comb begin
        ctrl    = CtrlNone;
        illegal = 1'b0;
        unique case (alu_op)
            AluOpMem:    ctrl = CtrlAdd;
            AluOpBranch: ctrl = CtrlSub;
            AluOpRtype: begin
                case (funct)
                    FunctAdd: ctrl = CtrlAdd;
                    FunctSub: ctrl = CtrlSub;
                    FunctAnd: ctrl = CtrlAnd;
                    FunctOr:  ctrl = CtrlOr;
                    FunctSlt: ctrl = CtrlSlt;
                    FunctNor: ctrl = CtrlNor;
                    FunctMul: ctrl = CtrlMul;
                    FunctDiv: ctrl = CtrlDiv;
                    default:  illegal = 1'b1;
                endcase
            end
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops with one registered cycle of latency,
// plus iterative shift-add MUL and restoring DIV that stall via in_ready.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_exec_unit_if.slave  bus
);

    localparam int unsigned       CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

    alu_ctrl_e        ctrl;
    logic             dec_illegal;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] hi_q;    // MUL partial product high / DIV partial remainder
    logic [WIDTH-1:0] lo_q;    // MUL multiplier bits / DIV dividend-then-quotient
    logic [WIDTH-1:0] opb_q;   // MUL multiplicand / DIV divisor

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] hi_out_q;
    logic             zero_q;
    logic             div_zero_q;
    logic             illegal_q;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH:0]   mul_add;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;

    alu_ctrl_decode u_decode (
        .alu_op  (bus.ALUop),
        .funct   (bus.Funct),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

    // Single-cycle result; DIV reaches this path only when the divisor is zero.
    always_comb begin
        alu_res = '0;
        alu_hi  = '0;
        case (ctrl)
            CtrlAdd: alu_res = bus.A + bus.B;
            CtrlSub: alu_res = bus.A - bus.B;
            CtrlAnd: alu_res = bus.A & bus.B;
            CtrlOr:  alu_res = bus.A | bus.B;
            CtrlNor: alu_res = ~(bus.A | bus.B);
            CtrlSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            CtrlDiv: begin
                alu_res = '1;
                alu_hi  = bus.A;
            end
            default: ;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_add   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opb_q}) : {1'b0, hi_q};
        mul_hi_n  = mul_add[WIDTH:1];
        mul_lo_n  = {mul_add[0], lo_q[WIDTH-1:1]};
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (!div_trial[WIDTH]) begin
            div_rem_n = div_trial[WIDTH-1:0];
            div_quo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_n = div_shift[WIDTH-1:0];
            div_quo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer and registered outputs; flags and out_valid default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_out_q    <= '0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (ctrl == CtrlMul) begin
                            state_q <= StMul;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= bus.B;
                            opb_q   <= bus.A;
                        end else if (ctrl == CtrlDiv && bus.B != '0) begin
                            state_q <= StDiv;
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            lo_q    <= bus.A;
                            opb_q   <= bus.B;
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            hi_out_q    <= alu_hi;
                            zero_q      <= (alu_res == '0);
                            div_zero_q  <= (ctrl == CtrlDiv);
                            illegal_q   <= dec_illegal;
                        end
                    end
                end
                StMul: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_lo_n;
                        hi_out_q    <= mul_hi_n;
                        zero_q      <= (mul_lo_n == '0);
                    end
                end
                StDiv: begin
                    hi_q  <= div_rem_n;
                    lo_q  <= div_quo_n;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b1;
                        result_q    <= div_quo_n;
                        hi_out_q    <= div_rem_n;
                        zero_q      <= (div_quo_n == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Hi        = hi_out_q;
    assign bus.Zero      = zero_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit: decodes ALUop/Funct into an internal 4-bit ALU control code and executes the operation. Single-cycle ops (ADD, SUB, AND, OR, SLT, NOR) complete with a one-cycle registered latency. MUL and DIV run as iterative multi-cycle sequences, and the unit backpressures the pipeline through `in_ready`. It sits in EX and feeds the EX/MEM register and the hazard/stall logic.

## Interface
- `WIDTH`, 32, operand/result width; must be at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request; the transfer occurs when `in_valid` and `in_ready` are both high.
- `ALUop`  in  2  00 = load/store (ADD), 01 = branch (SUB), 10 = R-type (decode Funct), 11 = illegal.
- `Funct`  in  6  R-type function field.
- `A`, `B`  in  WIDTH  operands; sampled only at transfer.
- `out_valid`  out  1  one-cycle pulse; result outputs are valid while it is high.
- `Result`  out  WIDTH  ALU result, MUL low half, or DIV quotient.
- `Hi`  out  WIDTH  MUL high half or DIV remainder; 0 for single-cycle ops.
- `Zero`  out  1  `Result == 0`.
- `div_zero`  out  1  DIV with B == 0.
- `illegal`  out  1  ALUop == 11, or an unlisted Funct with ALUop == 10.

## Operation
- Decode (Funct → control code):
  - ADD 100000 → 0010
  - SUB 100010 → 0110
  - AND 100100 → 0000
  - OR 100101 → 0001
  - SLT 101010 → 0111
  - NOR 100111 → 1100
  - MUL 100001 → 0100
  - DIV 100011 → 0101
  - ALUop 00 → 0010; ALUop 01 → 0110.
  - The decoder never latches a previous code. An undecoded request completes as a single-cycle op with `Result` = 0, `Hi` = 0, `illegal` = 1.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
  - SLT compares signed and returns 1 or 0, zero-extended.
  - MUL is unsigned, producing a 2·WIDTH-bit product `{Hi, Result}`, computed by a shift-add over WIDTH iterations.
  - DIV is unsigned restoring division over WIDTH iterations: quotient in `Result`, remainder in `Hi`.
- FSM states: IDLE, MUL, DIV.
  - IDLE: `in_ready` = 1. A transfer of a single-cycle op registers the outputs and pulses `out_valid` next cycle; the FSM stays in IDLE. A transfer of MUL or DIV with B ≠ 0 goes to MUL or DIV, loads the operands, and sets the iteration counter (width $clog2(WIDTH)+1) to 0.
  - DIV with B == 0: a single-cycle completion with `Result` = all ones, `Hi` = A, `div_zero` = 1.
  - MUL and DIV: `in_ready` = 0. One iteration per cycle. After iteration WIDTH−1 completes, register the results, pulse `out_valid` next cycle, and return to IDLE.
- There is no output backpressure; the consumer must capture the results during the `out_valid` pulse.
- `in_valid` while `in_ready` = 0 is ignored. The requester must hold the request until it is accepted.
- Flags (`Zero`, `div_zero`, `illegal`) are valid only with `out_valid`. They are held at 0 otherwise.

## Timing
- Reset values: state = IDLE, `in_ready` = 1, `out_valid` = 0, `Result` = 0, `Hi` = 0, `Zero` = 0, `div_zero` = 0, `illegal` = 0.
- Single-cycle op latency: transfer at edge N, `out_valid` high in cycle N+1.
- MUL/DIV latency: transfer at edge N, `in_ready` low for cycles N+1..N+WIDTH, `out_valid` high in cycle N+WIDTH+1 together with `in_ready` = 1.
- A new transfer is allowed in the same cycle as an `out_valid` pulse, so back-to-back single-cycle ops sustain 1 op per cycle.
- Reset mid-sequence aborts the operation. The next cycle shows reset values, with no `out_valid` pulse for the aborted op.
- `reset` takes priority over a simultaneous `in_valid`; that request is dropped.

## Structure
- Shared package `alu_pkg`: ALUop encodings, Funct constants, the 4-bit ALU control codes listed above, and the FSM state enum.
- Sub-module `alu_ctrl_decode`: a purely combinational ALUop/Funct → {control code, illegal} decoder, reusable by forwarding/hazard logic.
- The datapath (single-cycle ALU, shift-add multiplier, restoring divider) and the FSM stay in `alu_exec_unit`.

## Test plan
All scenarios use WIDTH = 32.
- **Single-cycle ops:**
  - ADD (ALUop 10, Funct 100000), A = 5, B = 7 → next cycle `out_valid` = 1, `Result` = 12, `Zero` = 0.
  - ALUop 01, A = B = 0x1234 → `Result` = 0, `Zero` = 1.
  - SLT, A = 0xFFFFFFFF, B = 1 → `Result` = 1.
- **MUL:** A = 0x10000, B = 0x10000 → `in_ready` low 32 cycles, `out_valid` 33 cycles after transfer, `Result` = 0, `Hi` = 1. An `in_valid` asserted while busy is not accepted.
- **DIV:**
  - A = 100, B = 7 → `Result` = 14, `Hi` = 2 at latency 33.
  - A = 9, B = 0 → latency 1, `Result` = 0xFFFFFFFF, `Hi` = 9, `div_zero` = 1.
- **Illegal decode:** ALUop 10, Funct 111111 → latency 1, `illegal` = 1, `Result` = 0.
- **Mid-sequence reset:** assert `reset` during the 10th cycle of a MUL → next cycle `in_ready` = 1 and all outputs 0. No `out_valid` pulse follows. A subsequent ADD 1 + 1 returns 2.
- **Back-to-back throughput:** ADD, SUB, AND, OR, NOR issued on consecutive edges → five consecutive `out_valid` pulses with the correct results in order.
